// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq -- registered SM83-style ALU with a persistent flag register.
//
// Executes the 8-bit-style ALU/CB operations on WIDTH-bit operands, owns the
// flag register F = {Z,N,H,C}, and performs the 2*WIDTH-bit ADDW (ADD HL,rr)
// in two cycles: the low halves are added at accept, and the high halves plus
// the low carry are added on the following edge.
// Results go into a one-deep output register with valid/ready on both sides.
//
// Optional feature macro: ALU_DAA_EN
//   defined   : opcode 19 is DAA (BCD adjust; the constants assume WIDTH=8)
//   undefined : opcode 19 acts as an unknown opcode and no DAA logic exists
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    request handshake (accept = in_valid & in_ready)
//   operation  [OP_W]      opcode
//   operand1   [2*WIDTH]   A / HL (upper half used only by ADDW)
//   operand2   [2*WIDTH]   source / rr; BIT index = operand2[2:0]
//   out_valid / out_ready  result handshake
//   result     [2*WIDTH]   result register (upper half zero except for ADDW)
//   flags      [4]         live F = {Z,N,H,C}
//   flag_load, flag_wdata  load F when no result commits on the same edge
// ----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int OP_W  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    operation,
   input  logic [2*WIDTH-1:0] operand1,
   input  logic [2*WIDTH-1:0] operand2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [3:0]         flags,
   input  logic               flag_load,
   input  logic [3:0]         flag_wdata
);
   localparam int HW = WIDTH / 2;

   // Encodings run consecutively from 0 (ADD) to 21 (CPL).
   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP,
      OP_INC, OP_DEC, OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA,
      OP_SWAP, OP_SRL, OP_BIT, OP_DAA, OP_ADDW, OP_CPL
   } op_e;

   typedef enum logic { S_IDLE, S_EXEC_HI } state_e;

   state_e             state_q, state_d;
   logic               out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [3:0]         flags_q, flags_d;

   // ADDW holding registers
   logic [WIDTH-1:0]   lo_sum_q, hi_a_q, hi_b_q;
   logic               lo_c_q;

   logic [WIDTH-1:0]   a, b;
   logic               c_in, cin_arith;
   logic [WIDTH:0]     add_w, sub_w, hi_w;
   logic [HW:0]        add_h, sub_h, hi_h;

   assign a         = operand1[WIDTH-1:0];
   assign b         = operand2[WIDTH-1:0];
   assign c_in      = flags_q[0];
   assign cin_arith = (operation == OP_ADC || operation == OP_SBC) ? c_in : 1'b0;

   // Extra top bit gives carry (add) or borrow (subtract) out of each boundary.
   assign add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_arith};
   assign sub_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_arith};
   assign add_h = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + {{HW{1'b0}}, cin_arith};
   assign sub_h = {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} - {{HW{1'b0}}, cin_arith};

   assign hi_w  = {1'b0, hi_a_q} + {1'b0, hi_b_q} + {{WIDTH{1'b0}}, lo_c_q};
   assign hi_h  = {1'b0, hi_a_q[HW-1:0]} + {1'b0, hi_b_q[HW-1:0]} + {{HW{1'b0}}, lo_c_q};

`ifdef ALU_DAA_EN
   logic             daa_hi, daa_lo;
   logic [WIDTH-1:0] daa_adj, daa_res;

   // After a subtraction (N=1) only the recorded H/C drive the correction,
   // so C can never be cleared there.
   always_comb begin
      daa_hi  = flags_q[2] ? flags_q[0] : (flags_q[0] || a > WIDTH'('h99));
      daa_lo  = flags_q[2] ? flags_q[1] : (flags_q[1] || a[3:0] > 4'h9);
      daa_adj = (daa_hi ? WIDTH'('h60) : '0) | (daa_lo ? WIDTH'('h06) : '0);
      daa_res = flags_q[2] ? (a - daa_adj) : (a + daa_adj);
   end
`endif

   // ---------------------------------------------------------------------
   // Single-cycle ALU function
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] alu_res;
   logic             z_f, n_f, h_f, c_f, z_from_res;

   // NOTE: every output of a combinational block gets a default before the
   // case statement, so no path leaves a signal unassigned (no latches).
   always_comb begin
      alu_res    = a;
      z_f        = flags_q[3];
      n_f        = flags_q[2];
      h_f        = flags_q[1];
      c_f        = flags_q[0];
      z_from_res = 1'b0;
      case (operation)
         OP_ADD, OP_ADC: begin
            alu_res = add_w[WIDTH-1:0]; n_f = 1'b0; h_f = add_h[HW]; c_f = add_w[WIDTH];
            z_from_res = 1'b1;
         end
         OP_SUB, OP_SBC: begin
            alu_res = sub_w[WIDTH-1:0]; n_f = 1'b1; h_f = sub_h[HW]; c_f = sub_w[WIDTH];
            z_from_res = 1'b1;
         end
         // CP keeps A but reports Z from the difference, as SUB would.
         OP_CP: begin
            n_f = 1'b1; h_f = sub_h[HW]; c_f = sub_w[WIDTH];
            z_f = (sub_w[WIDTH-1:0] == '0);
         end
         OP_AND: begin
            alu_res = a & b; n_f = 1'b0; h_f = 1'b1; c_f = 1'b0; z_from_res = 1'b1;
         end
         OP_XOR: begin
            alu_res = a ^ b; n_f = 1'b0; h_f = 1'b0; c_f = 1'b0; z_from_res = 1'b1;
         end
         OP_OR: begin
            alu_res = a | b; n_f = 1'b0; h_f = 1'b0; c_f = 1'b0; z_from_res = 1'b1;
         end
         OP_INC: begin
            alu_res = a + WIDTH'(1); n_f = 1'b0; h_f = &a[HW-1:0]; z_from_res = 1'b1;
         end
         OP_DEC: begin
            alu_res = a - WIDTH'(1); n_f = 1'b1; h_f = ~|a[HW-1:0]; z_from_res = 1'b1;
         end
         OP_RLC: begin
            alu_res = {a[WIDTH-2:0], a[WIDTH-1]}; n_f = 1'b0; h_f = 1'b0; c_f = a[WIDTH-1];
            z_from_res = 1'b1;
         end
         OP_RRC: begin
            alu_res = {a[0], a[WIDTH-1:1]}; n_f = 1'b0; h_f = 1'b0; c_f = a[0];
            z_from_res = 1'b1;
         end
         OP_RL: begin
            alu_res = {a[WIDTH-2:0], c_in}; n_f = 1'b0; h_f = 1'b0; c_f = a[WIDTH-1];
            z_from_res = 1'b1;
         end
         OP_RR: begin
            alu_res = {c_in, a[WIDTH-1:1]}; n_f = 1'b0; h_f = 1'b0; c_f = a[0];
            z_from_res = 1'b1;
         end
         OP_SLA: begin
            alu_res = {a[WIDTH-2:0], 1'b0}; n_f = 1'b0; h_f = 1'b0; c_f = a[WIDTH-1];
            z_from_res = 1'b1;
         end
         OP_SRA: begin
            alu_res = {a[WIDTH-1], a[WIDTH-1:1]}; n_f = 1'b0; h_f = 1'b0; c_f = a[0];
            z_from_res = 1'b1;
         end
         OP_SWAP: begin
            alu_res = {a[HW-1:0], a[WIDTH-1:HW]}; n_f = 1'b0; h_f = 1'b0; c_f = 1'b0;
            z_from_res = 1'b1;
         end
         OP_SRL: begin
            alu_res = {1'b0, a[WIDTH-1:1]}; n_f = 1'b0; h_f = 1'b0; c_f = a[0];
            z_from_res = 1'b1;
         end
         // Mask form keeps an index beyond WIDTH-1 legal (reads as a zero bit).
         OP_BIT: begin
            z_f = ~|(a & (WIDTH'(1) << operand2[2:0])); n_f = 1'b0; h_f = 1'b1;
         end
         OP_CPL: begin
            alu_res = ~a; n_f = 1'b1; h_f = 1'b1;
         end
`ifdef ALU_DAA_EN
         OP_DAA: begin
            alu_res = daa_res; h_f = 1'b0; c_f = daa_hi; z_from_res = 1'b1;
         end
`endif
         // Unknown codes pass A through with F untouched; ADDW is handled
         // by the two-cycle path and never commits from here.
         default: ;
      endcase
      if (z_from_res) z_f = (alu_res == '0);
   end

   // ---------------------------------------------------------------------
   // Handshake, state and commit
   // ---------------------------------------------------------------------
   logic               accept, commit;
   logic [2*WIDTH-1:0] commit_res;
   logic [3:0]         commit_flags;

   // Held low during reset so nothing is accepted before release.
   assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      commit       = 1'b0;
      commit_res   = result_q;
      commit_flags = flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (operation == OP_ADDW) begin
                  state_d = S_EXEC_HI;
               end else begin
                  commit       = 1'b1;
                  commit_res   = {{WIDTH{1'b0}}, alu_res};
                  commit_flags = {z_f, n_f, h_f, c_f};
               end
            end
         end
         S_EXEC_HI: begin
            commit       = 1'b1;
            commit_res   = {hi_w[WIDTH-1:0], lo_sum_q};
            commit_flags = {flags_q[3], 1'b0, hi_h[HW], hi_w[WIDTH]};
            state_d      = S_IDLE;
         end
      endcase

      result_d    = commit ? commit_res : result_q;
      out_valid_d = commit || (out_valid_q && !out_ready);
      // A committing op owns F on its edge; a coincident flag_load is dropped.
      if (commit)         flags_d = commit_flags;
      else if (flag_load) flags_d = flag_wdata;
      else                flags_d = flags_q;
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= 4'b0000;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   // NOTE: ADDW holding registers carry no reset; they are always loaded on
   // the accept edge before EXEC_HI reads them.
   always_ff @(posedge clk) begin
      if (accept && operation == OP_ADDW) begin
         lo_sum_q <= add_w[WIDTH-1:0];
         lo_c_q   <= add_w[WIDTH];
         hi_a_q   <= operand1[2*WIDTH-1:WIDTH];
         hi_b_q   <= operand2[2*WIDTH-1:WIDTH];
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule
